// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder family.
package serial_adder_pkg;

    typedef enum logic {MODE_ADD, MODE_SUB} mode_t;

    // Width of a counter that must hold 0..max_digits.
    function automatic int unsigned cnt_width(input int unsigned max_digits);
        return $clog2(max_digits + 1);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// One W-bit digit of a ripple add: s/cout plus the carry into the top bit.
// SERIAL_ADDER_DIGIT_OVF_EN enables the c_msb output; otherwise it is tied to 0.
module digit_adder #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s     = total[W-1:0];
    assign cout  = total[W];

`ifdef SERIAL_ADDER_DIGIT_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit and its two operands.
    assign c_msb = total[W-1] ^ a[W-1] ^ b[W-1];
`else
    assign c_msb = 1'b0;
`endif

endmodule

// File: rtl/serial_adder_digit_vld.sv
// Digit-serial adder/subtractor, LSB digit first, framed by vld/last with a
// MAX_DIGITS length guard. All outputs registered, one cycle of latency.
// SERIAL_ADDER_DIGIT_OVF_EN enables the signed-overflow flag; otherwise ovf is 0.
module serial_adder_digit_vld
    import serial_adder_pkg::*;
#(
    parameter int unsigned W          = 4,
    parameter int unsigned MAX_DIGITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         last,
    output logic [W-1:0] sum,
    output logic         sum_vld,
    output logic         sum_last,
    output logic         carry_out,
    output logic         ovf,
    output logic         err
);

    localparam int unsigned    CW       = cnt_width(MAX_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_DIGITS - 1);

    logic          first_q;
    mode_t         sub_q;
    logic          c_q;
    logic [CW-1:0] cnt_q;

    logic          m;
    logic [W-1:0]  b_eff;
    logic          cin;
    logic [W-1:0]  s;
    logic          c_nxt;
    logic          c_msb;
    logic          end_w;

    // Mode comes straight from the port on a word's first digit, else from the latch.
    assign m     = first_q ? sub : (sub_q == MODE_SUB);
    assign b_eff = m ? ~b : b;
    assign cin   = first_q ? m : c_q;
    assign end_w = vld & (last | (cnt_q == CNT_LAST));

    digit_adder #(
        .W (W)
    ) u_digit_adder (
        .a     (a),
        .b     (b_eff),
        .cin   (cin),
        .s     (s),
        .cout  (c_nxt),
        .c_msb (c_msb)
    );

    // Word framing state: carry, digit count, first-digit flag and latched mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b1;
            sub_q   <= MODE_ADD;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else if (vld) begin
            if (first_q) begin
                sub_q <= sub ? MODE_SUB : MODE_ADD;
            end
            if (end_w) begin
                c_q     <= 1'b0;
                cnt_q   <= '0;
                first_q <= 1'b1;
            end else begin
                c_q     <= c_nxt;
                cnt_q   <= cnt_q + 1'b1;
                first_q <= 1'b0;
            end
        end
    end

    // Output registers; word-end flags are only ever high alongside sum_last.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            sum_vld   <= 1'b0;
            sum_last  <= 1'b0;
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (vld) begin
                sum <= s;
            end
            sum_vld   <= vld;
            sum_last  <= end_w;
            carry_out <= end_w & c_nxt;
            err       <= end_w & ~last;
        end
    end

`ifdef SERIAL_ADDER_DIGIT_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= end_w & (c_nxt ^ c_msb);
        end
    end
`else
    logic unused_c_msb;
    assign unused_c_msb = c_msb;
    assign ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_digit_vld.sv
// Scoreboard bench for serial_adder_digit_vld (W=4, MAX_DIGITS=4).
module tb_serial_adder_digit_vld;

    localparam int unsigned W   = 4;
    localparam int unsigned MAXD = 4;
`ifdef SERIAL_ADDER_DIGIT_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vld = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         last = 1'b0;
    logic [W-1:0] sum;
    logic         sum_vld;
    logic         sum_last;
    logic         carry_out;
    logic         ovf;
    logic         err;

    serial_adder_digit_vld #(
        .W          (W),
        .MAX_DIGITS (MAXD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .last      (last),
        .sum       (sum),
        .sum_vld   (sum_vld),
        .sum_last  (sum_last),
        .carry_out (carry_out),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        bit           l;
        bit           c;
        bit           o;
        bit           e;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Word-level reference model: operands accumulated as integers.
    bit     m_first = 1'b1;
    bit     m_sub   = 1'b0;
    longint m_pa    = 0;
    longint m_pb    = 0;
    int     m_n     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Evaluate the whole prefix of the word and take its newest digit.
    task automatic model_digit(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input bit sv, input bit lv);
        longint mask, beff, tot, res;
        int     bits;
        bit     cout, sa, sb, sr, ov, endw;
        exp_t   e;
        if (m_first) begin
            m_sub = sv;
            m_pa  = 0;
            m_pb  = 0;
            m_n   = 0;
        end
        m_pa = m_pa + (longint'(av) << (W * m_n));
        m_pb = m_pb + (longint'(bv) << (W * m_n));
        m_n++;
        bits = W * m_n;
        mask = (longint'(1) << bits) - 1;
        beff = m_sub ? (~m_pb & mask) : m_pb;
        tot  = m_pa + beff + (m_sub ? 1 : 0);
        res  = tot & mask;
        cout = ((tot >> bits) & 1) != 0;
        sa   = ((m_pa >> (bits - 1)) & 1) != 0;
        sb   = ((m_pb >> (bits - 1)) & 1) != 0;
        sr   = ((res >> (bits - 1)) & 1) != 0;
        ov   = m_sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        endw = lv || (m_n == MAXD);
        e.s  = W'((res >> (W * (m_n - 1))) & 'hF);
        e.l  = endw;
        e.c  = endw && cout;
        e.o  = endw && ov && OVF_EN;
        e.e  = endw && !lv;
        q.push_back(e);
        m_first = endw;
    endtask

    task automatic put(input bit v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit sv, input bit lv);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        vld  = v;
        a    = av;
        b    = bv;
        sub  = sv;
        last = lv;
        if (v) model_digit(av, bv, sv, lv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst  = 1'b1;
        vld  = 1'($urandom);
        a    = W'($urandom);
        b    = W'($urandom);
        sub  = 1'($urandom);
        last = 1'($urandom);
        m_first = 1'b1;
    endtask

    // Word 0x1234 + 0x0FFF, optionally with gaps between digits.
    task automatic word_case1(input int gap, input int ndig);
        logic [W-1:0] av [4];
        logic [W-1:0] bv [4];
        av = '{4'h4, 4'h3, 4'h2, 4'h1};
        bv = '{4'hF, 4'hF, 4'hF, 4'h0};
        for (int i = 0; i < ndig; i++) begin
            put(1'b1, av[i], bv[i], 1'b0, i == 3);
            if (i != ndig - 1) idle(gap);
        end
    endtask

    // Monitor: compare every presented digit against the scoreboard head.
    logic [W-1:0] exp_hold = '0;
    bit           rst_prev = 1'b1;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                chk("rst_sum", 32'(sum), 32'd0);
                chk("rst_flags", {27'd0, sum_vld, sum_last, carry_out, ovf, err}, 32'd0);
                exp_hold = '0;
            end else if (sum_vld === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_sum_vld", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sum", 32'(sum), 32'(e.s));
                    chk("sum_last", 32'(sum_last), 32'(e.l));
                    chk("carry_out", 32'(carry_out), 32'(e.c));
                    chk("ovf", 32'(ovf), 32'(e.o));
                    chk("err", 32'(err), 32'(e.e));
                    exp_hold = e.s;
                end
            end else begin
                chk("idle_sum_hold", 32'(sum), 32'(exp_hold));
                chk("idle_flags", {28'd0, sum_last, carry_out, ovf, err}, 32'd0);
            end
            rst_prev = rst;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle(0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        idle(2);

        word_case1(0, 4);
        // 0x0005 - 0x0007; sub only on the first digit
        put(1'b1, 4'h5, 4'h7, 1'b1, 1'b0);
        put(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        put(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        put(1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
        // 0x7FFF + 0x0001
        put(1'b1, 4'hF, 4'h1, 1'b0, 1'b0);
        put(1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
        put(1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
        put(1'b1, 4'h7, 4'h0, 1'b0, 1'b1);
        idle(1);
        word_case1(2, 4);
        // single-digit words back to back
        put(1'b1, 4'h9, 4'h8, 1'b0, 1'b1);
        put(1'b1, 4'h1, 4'h1, 1'b0, 1'b1);
        // length guard: five digits with no last
        for (int i = 0; i < 5; i++) put(1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
        put(1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
        idle(1);
        // reset mid-word, then a fresh word
        word_case1(0, 2);
        do_reset();
        idle(1);
        put(1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
        put(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        put(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        put(1'b1, 4'h0, 4'h0, 1'b0, 1'b1);

        // randomized traffic with gaps, mixed modes and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                put($urandom_range(3) != 0, W'($urandom), W'($urandom), 1'($urandom),
                    $urandom_range(2) == 0);
            end
        end
        idle(3);
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_digit_vld.md
# serial_adder_digit_vld

Digit-serial adder/subtractor for the sequential-arithmetic family. It adds or subtracts two operands streamed least-significant digit first, `W` bits per cycle. Words are framed by `vld`/`last`, with per-word mode select and a word-length guard. Outputs are registered and carry carry-out, signed overflow and framing flags, so the block can feed a downstream serial consumer directly.

## Interface
- `W`, 4: digit width in bits; must be ≥ 1.
- `MAX_DIGITS`, 8: maximum digits per word; must be ≥ 1.

- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset. Synchronous and active-high; every state register and output clears on it.
- `vld`  in  1  input digit valid.
- `a`  in  W  operand A digit.
- `b`  in  W  operand B digit.
- `sub`  in  1  mode, 1 = A − B, 0 = A + B. Sampled only on the first digit of a word.
- `last`  in  1  current digit is the word's most significant digit; meaningful only with `vld`.
- `sum`  out  W  result digit.
- `sum_vld`  out  1  `sum` is valid.
- `sum_last`  out  1  `sum` is the final digit of the word.
- `carry_out`  out  1  carry out of the final digit. Valid with `sum_last`, 0 otherwise. For subtraction, 1 means no borrow.
- `ovf`  out  1  two's-complement overflow of the word. Valid with `sum_last`, 0 otherwise.
- `err`  out  1  word was force-terminated at `MAX_DIGITS`. Valid with `sum_last`, 0 otherwise.

## Operation
- State: `first` flag, reset 1 (the next valid digit opens a word).
- State: latched mode `sub_q`.
- State: carry register `c`.
- State: digit counter `cnt`, `$clog2(MAX_DIGITS+1)` bits.
- Effective mode `m = first ? sub : sub_q`.
- Effective B: `b_eff = m ? ~b : b`.
- Carry-in: `cin = first ? m : c`.
- Digit result: `{c_nxt, s} = a + b_eff + cin`, computed at W+1 bits.
- `c_msb` is the carry into bit W−1 of that add.
- Word end: `end_w = vld & (last | cnt == MAX_DIGITS-1)`.
- On `vld & first`: latch `sub_q <= sub`.
- On `vld & ~end_w`: `c <= c_nxt`, `cnt <= cnt+1`, `first <= 0`.
- On `vld & end_w`: `c <= 0`, `cnt <= 0`, `first <= 1`.
- `vld` = 0: all state holds. Gaps are allowed anywhere inside a word.
- Forced termination: when `cnt == MAX_DIGITS-1` and `last` = 0, the digit still ends the word and `err` is flagged. A subsequent digit opens a new word.
- `last` on the first digit is legal and gives a single-digit word.
- `rst` mid-word discards the partial word, and no `sum_last` is emitted for it.

## Timing
- Latency is 1 cycle: the digit accepted at edge k appears on `sum`/`sum_vld` after edge k.
- Back-to-back words run at full rate with no bubble. The first digit of the next word never sees a stale carry.
- Registered on every accepted digit: `sum <= s` and `sum_vld <= vld`.
- Registered on the word-end digit: `sum_last <= end_w`, `carry_out <= end_w & c_nxt`, `ovf <= end_w & (c_nxt ^ c_msb)`, `err <= end_w & ~last`.
- When `vld` = 0 the next cycle has `sum_vld` = `sum_last` = `carry_out` = `ovf` = `err` = 0, and `sum` holds its last value.
- Reset value of every output is 0.

## Configuration
- `SERIAL_ADDER_DIGIT_OVF_EN` defined: `ovf` is computed as above.
- Not defined: `ovf` is tied to 0 and the `c_msb` logic is removed. Ports are unchanged.

## Structure
- Package `serial_adder_pkg` holds:
  - `typedef enum logic {MODE_ADD, MODE_SUB} mode_t`;
  - the counter-width helper function.
- Sub-module `digit_adder #(W)` is purely combinational, with inputs `a`, `b`, `cin` and outputs `s`, `cout`, `c_msb`. The top level holds the framing, the state, and the output registers.

## Test plan
(W=4, MAX_DIGITS=4; digits listed LSB first)
- Add 0x1234+0x0FFF: a=4,3,2,1 and b=F,F,F,0, `last` on digit 4. Expect `sum`=3,3,2,2 (0x2233), `carry_out`=0, `ovf`=0, `sum_last` only on digit 4.
- Sub 0x0005−0x0007 (`sub`=1 on digit 1, then 0 on later digits to prove the latch). Expect `sum`=E,F,F,F (0xFFFE), `carry_out`=0, `ovf`=0.
- Overflow 0x7FFF+0x0001. Expect 0x8000 and `ovf`=1 with the macro, `ovf`=0 without.
- Gaps and back-to-back words:
  - Repeat the first case with `vld` low for 2 cycles between every pair of digits: identical results.
  - Then 1-digit words 9+8 followed immediately by 1+1: expect `sum`=1 with `carry_out`=1, then `sum`=2 with `carry_out`=0.
- Length guard: 5 valid digits of 1+1 with no `last`. Expect `sum_last`=1 and `err`=1 on digit 4. Digit 5 is the first digit of a new word, with `sum`=2 and cin=0.
- Reset mid-word: assert `rst` after 2 digits of the first case. Expect all outputs 0 next cycle. A fresh 0x0001+0x0001 word then gives `sum`=2,0,0,0.
